sine_wave_meter: RTL

Measures an incoming unsigned offset-binary sine sample stream, the receive-side counterpart of the sine generator. A hysteresis (Schmitt) comparator detects rising mid-scale crossings and counts valid samples between consecutive crossings to give the period. The block also tracks peak and trough over each period. It sits after an ADC or a loopback of the generator output, and reports period, peak and trough once per measured period, with lock and timeout status.

---
 rtl/sine_wave_meter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sine_wave_meter.sv
// sine_wave_meter: period / peak / trough meter for an offset-binary sine stream.
// A Schmitt comparator (thresholds MID+HYST / MID-HYST) finds rising crossings;
// valid samples between consecutive crossings give the period, and the run
// max/min over the same span give peak and trough.
// Optional feature: define SINE_METER_AVG_EN to report averages over 4 periods.
module sine_wave_meter #(
  parameter int SINE_SIZE   = 12,
  parameter int PERIOD_SIZE = 16,
  parameter int HYST        = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [SINE_SIZE-1:0]   sample,
  input  logic                   sampleValid,
  output logic [PERIOD_SIZE-1:0] period,
  output logic [SINE_SIZE-1:0]   peak,
  output logic [SINE_SIZE-1:0]   trough,
  output logic                   measValid,
  output logic                   locked,
  output logic                   timeout
);

  localparam logic [SINE_SIZE-1:0]   HI_TH   = SINE_SIZE'((1 << (SINE_SIZE-1)) + HYST);
  localparam logic [SINE_SIZE-1:0]   LO_TH   = SINE_SIZE'((1 << (SINE_SIZE-1)) - HYST);
  localparam logic [PERIOD_SIZE-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_SIZE-1:0] CNT_ONE = PERIOD_SIZE'(1);

  typedef enum logic [1:0] {S_SEEK, S_ARM, S_LOW, S_HIGH} state_t;

  state_t                 state;
  logic [PERIOD_SIZE-1:0] cnt;
  logic [SINE_SIZE-1:0]   run_max, run_min;

  logic                   hi, lo, at_max;
  logic [SINE_SIZE-1:0]   nxt_max, nxt_min;

  // Comparator decisions and running extremes including the current sample.
  always_comb begin
    hi      = (sample >= HI_TH);
    lo      = (sample <= LO_TH);
    at_max  = (cnt == CNT_MAX);
    nxt_max = (sample > run_max) ? sample : run_max;
    nxt_min = (sample < run_min) ? sample : run_min;
  end

`ifdef SINE_METER_AVG_EN
  logic [1:0]             ev_cnt;
  logic [PERIOD_SIZE+1:0] acc;
  logic [PERIOD_SIZE+1:0] acc_sum;
  logic [SINE_SIZE-1:0]   agg_max, agg_min, agg_max_n, agg_min_n;

  // Fold the period just closed into the 4-period aggregate.
  always_comb begin
    acc_sum   = acc + {2'b00, cnt};
    agg_max_n = (ev_cnt == 2'd0 || run_max > agg_max) ? run_max : agg_max;
    agg_min_n = (ev_cnt == 2'd0 || run_min < agg_min) ? run_min : agg_min;
  end
`endif

  // Measurement FSM; only valid samples advance state, outputs are registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_SEEK;
      cnt       <= '0;
      run_max   <= '0;
      run_min   <= '0;
      period    <= '0;
      peak      <= '0;
      trough    <= '0;
      measValid <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
`ifdef SINE_METER_AVG_EN
      ev_cnt    <= '0;
      acc       <= '0;
      agg_max   <= '0;
      agg_min   <= '0;
`endif
    end else begin
      measValid <= 1'b0;
      timeout   <= 1'b0;
      if (sampleValid) begin
        case (state)
          S_SEEK: begin
            if (lo) begin
              state <= S_ARM;
              cnt   <= '0;
            end
          end
          S_ARM, S_LOW, S_HIGH: begin
            if (hi && state != S_LOW) begin
              // Rising event: the event sample opens the next period.
              if (state == S_HIGH) begin
`ifdef SINE_METER_AVG_EN
                if (ev_cnt == 2'd3) begin
                  period    <= PERIOD_SIZE'(acc_sum >> 2);
                  peak      <= agg_max_n;
                  trough    <= agg_min_n;
                  measValid <= 1'b1;
                  locked    <= 1'b1;
                  acc       <= '0;
                  ev_cnt    <= '0;
                end else begin
                  acc       <= acc_sum;
                  agg_max   <= agg_max_n;
                  agg_min   <= agg_min_n;
                  ev_cnt    <= ev_cnt + 2'd1;
                end
`else
                period    <= cnt;
                peak      <= run_max;
                trough    <= run_min;
                measValid <= 1'b1;
                locked    <= 1'b1;
`endif
              end
              cnt     <= CNT_ONE;
              run_max <= sample;
              run_min <= sample;
              state   <= S_LOW;
            end else if (at_max) begin
              // Loss of signal: no event within the counter range.
              timeout <= 1'b1;
              locked  <= 1'b0;
              state   <= S_SEEK;
`ifdef SINE_METER_AVG_EN
              acc     <= '0;
              ev_cnt  <= '0;
`endif
            end else begin
              cnt <= cnt + CNT_ONE;
              if (state != S_ARM) begin
                run_max <= nxt_max;
                run_min <= nxt_min;
              end
              if (state == S_LOW && lo) state <= S_HIGH;
            end
          end
          default: state <= S_SEEK;
        endcase
      end
    end
  end

endmodule
